aes_in_packer: RTL and testbench
================================

# aes_in_packer

Upstream feeder for the AES128 core. It assembles a stream of 32-bit plaintext words into 128-bit blocks and double-buffers them. It issues each block to the core as a single-cycle `data_in_valid` pulse once the round keys are ready and the core is idle. It holds off the next block until the core reports `data_out_valid`, so at most one block is in flight.

## Interface
- No parameters. Word width 32, block = 4 words; both are fixed.
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset, synchronous and active-high (1 = reset); name kept per codebase convention.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  packer accepts word this cycle.
- `s_data`  in  32  plaintext word; first word of a block maps to `data_in[127:96]`, fourth to `[31:0]`.
- `s_last`  in  1  word is last of message; closes the block early with zero padding.
- `rk_ready`  in  1  from AES core: round keys valid.
- `aes_state`  in  1  from AES core: 1 = encrypting.
- `data_out_valid`  in  1  from AES core: ciphertext done pulse.
- `data_in_valid`  out  1  one-cycle block-issue pulse to core.
- `data_in`  out  128  block to core; stable from issue until next issue.
- `data_in_last`  out  1  issued block contained `s_last`; same timing as `data_in`.
- `busy`  out  1  block in flight or buffered.
- `blk_count`  out  16  blocks issued since reset, wraps 0xFFFF->0.

## Operation
- Assembly register A with word counter `wcnt` (0..3) and flag `a_done`. Holding register H with flag `h_full`. Each stage also carries a last bit.
- Word accept: `s_valid && s_ready`. The word is written to A slot `wcnt`, then `wcnt++`.
  - `a_done` sets when `wcnt==3` or `s_last`.
  - On `s_last` with `wcnt<3`, the remaining slots are forced to 0 and the A last bit sets.
  - `wcnt` returns to 0 when A moves to H.
- `s_ready = !a_done` (combinational from registers); it is 0 while `rstn` is high.
- A->H move: occurs in the cycle where `a_done` is set and either `h_full==0` or H is issuing that same cycle. The move clears `a_done` and sets `h_full`.
- Issue FSM, states IDLE and WAIT:
  - IDLE->WAIT when `h_full && rk_ready && !aes_state`. In that cycle, `data_in<=H`, `data_in_last<=H.last`, `data_in_valid<=1` (registered, one cycle), `h_full` clears, `blk_count++`.
  - WAIT->IDLE on `data_out_valid`. No issue may occur in that same cycle; the earliest re-issue is the following cycle.
  - `data_out_valid` in IDLE is ignored.
- `busy = h_full | a_done | (state==WAIT)`.
- `blk_count` adds 1 modulo 2^16.

## Timing
- Reset values: `s_ready` 0 (1 from the first cycle after reset deasserts), `data_in_valid` 0, `data_in` 0, `data_in_last` 0, `busy` 0, `blk_count` 0. Internal state: `wcnt` 0, FSM IDLE, A/H empty.
- Latency, fourth word accepted at cycle T with H empty and core ready:
  - `a_done` at T+1, move at T+1, `h_full` at T+2.
  - `data_in_valid` high at T+3.
- `s_ready` drops the cycle after the fourth (or `s_last`) word is accepted. It rises the cycle after the move.
- Throughput: with the core stalled, A and H both fill (8 words accepted), then `s_ready` stays 0.
- Simultaneous issue of H and move of A->H in one cycle: H takes the new block, `h_full` stays 1, and there is no bubble.
- `s_last` on the fourth word: a normal full block with the last bit set, no padding.
- `rk_ready` low: blocks buffer but never issue. `aes_state` high in IDLE also blocks issue.
- Reset mid-operation (any state): everything returns to reset values next cycle. A and H contents are discarded. A `data_out_valid` for the abandoned block arriving after reset is ignored.

## Test plan
- Reset, `rk_ready=1`. Send words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - Required: one `data_in_valid` pulse, exactly 3 cycles after the fourth accept.
  - Required: `data_in=0x00112233_44556677_8899AABB_CCDDEEFF`, `data_in_last=0`, `blk_count=1`.
- Send 2 words, the second with `s_last`.
  - Required: `data_in=0xW0_W1_00000000_00000000`, `data_in_last=1`.
  - Required: the next message starts at `wcnt=0`.
- Hold `data_out_valid` low after the first issue and stream 12 words.
  - Required: exactly 8 accepted, then `s_ready=0`, no second pulse.
  - Required: after `data_out_valid`, the second block issues on the next cycle and the third block follows after the next `data_out_valid`.
- `rk_ready=0` with a full block buffered.
  - Required: no issue, `busy=1`.
  - Required: raising `rk_ready` issues the block 1 cycle later.
- Assert `rstn` in WAIT with H full, then pulse `data_out_valid` after reset.
  - Required: all outputs return to reset values and no pulse is issued.
  - Required: `blk_count=0` and stays 0.
- Issue 65536 blocks (core model acks each).
  - Required: `blk_count` wraps to 0.

Source files
------------

// File: rtl/aes_in_packer.sv
// Packs 32-bit plaintext words into 128-bit blocks for the AES128 core.
// Two-stage buffer (assembly A, holding H) with one block in flight at a time.
module aes_in_packer (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic         rk_ready,
    input  logic         aes_state,
    input  logic         data_out_valid,
    output logic         data_in_valid,
    output logic [127:0] data_in,
    output logic         data_in_last,
    output logic         busy,
    output logic [15:0]  blk_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0][31:0]   a_word_q, a_word_d;
    logic [1:0]         wcnt_q, wcnt_d;
    logic               a_done_q, a_done_d;
    logic               a_last_q, a_last_d;
    logic [127:0]       h_data_q, h_data_d;
    logic               h_full_q, h_full_d;
    logic               h_last_q, h_last_d;
    logic [127:0]       data_in_q, data_in_d;
    logic               data_in_last_q, data_in_last_d;
    logic               data_in_valid_q, data_in_valid_d;
    logic [15:0]        blk_count_q, blk_count_d;

    logic word_acc;
    logic issue;
    logic move;

    // rstn is active-high here despite its name; hold off words during reset.
    assign s_ready  = !a_done_q && !rstn;
    assign word_acc = s_valid && s_ready;
    assign issue    = (state_q == ST_IDLE) && h_full_q && rk_ready && !aes_state;
    assign move     = a_done_q && (!h_full_q || issue);

    // Slot gi takes the incoming word, or zero when s_last closes the block before it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            localparam logic [1:0] SLOT = 2'(gi);
            assign a_word_d[gi] = (word_acc && wcnt_q == SLOT)          ? s_data :
                                  (word_acc && s_last && SLOT > wcnt_q) ? 32'd0  :
                                  a_word_q[gi];
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        a_done_d        = a_done_q;
        a_last_d        = a_last_q;
        h_data_d        = h_data_q;
        h_full_d        = h_full_q;
        h_last_d        = h_last_q;
        data_in_d       = data_in_q;
        data_in_last_d  = data_in_last_q;
        data_in_valid_d = 1'b0;
        blk_count_d     = blk_count_q;

        if (word_acc) begin
            wcnt_d = wcnt_q + 2'd1;
            if (s_last || wcnt_q == 2'd3) begin
                a_done_d = 1'b1;
            end
            if (s_last) begin
                a_last_d = 1'b1;
            end
        end

        // A move while H issues keeps h_full set: no bubble between blocks.
        if (move) begin
            wcnt_d   = 2'd0;
            a_done_d = 1'b0;
            a_last_d = 1'b0;
            h_data_d = {a_word_q[0], a_word_q[1], a_word_q[2], a_word_q[3]};
            h_last_d = a_last_q;
            h_full_d = 1'b1;
        end else if (issue) begin
            h_full_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d         = ST_WAIT;
                    data_in_d       = h_data_q;
                    data_in_last_d  = h_last_q;
                    data_in_valid_d = 1'b1;
                    blk_count_d     = blk_count_q + 16'd1;
                end
            end
            ST_WAIT: begin
                if (data_out_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q         <= ST_IDLE;
            a_word_q        <= '0;
            wcnt_q          <= 2'd0;
            a_done_q        <= 1'b0;
            a_last_q        <= 1'b0;
            h_data_q        <= '0;
            h_full_q        <= 1'b0;
            h_last_q        <= 1'b0;
            data_in_q       <= '0;
            data_in_last_q  <= 1'b0;
            data_in_valid_q <= 1'b0;
            blk_count_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            a_word_q        <= a_word_d;
            wcnt_q          <= wcnt_d;
            a_done_q        <= a_done_d;
            a_last_q        <= a_last_d;
            h_data_q        <= h_data_d;
            h_full_q        <= h_full_d;
            h_last_q        <= h_last_d;
            data_in_q       <= data_in_d;
            data_in_last_q  <= data_in_last_d;
            data_in_valid_q <= data_in_valid_d;
            blk_count_q     <= blk_count_d;
        end
    end

    assign data_in_valid = data_in_valid_q;
    assign data_in       = data_in_q;
    assign data_in_last  = data_in_last_q;
    assign blk_count     = blk_count_q;
    assign busy          = h_full_q | a_done_q | (state_q == ST_WAIT);

endmodule

// File: tb/tb_aes_in_packer.sv
// Directed bench for aes_in_packer: table of block vectors plus hand-written
// stall, key-not-ready, reset-in-flight and counter-wrap sequences.
module tb_aes_in_packer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic         rk_ready;
    logic         aes_state;
    logic         data_out_valid;
    logic         data_in_valid;
    logic [127:0] data_in;
    logic         data_in_last;
    logic         busy;
    logic [15:0]  blk_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_in_packer dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .rk_ready       (rk_ready),
        .aes_state      (aes_state),
        .data_out_valid (data_out_valid),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .data_in_last   (data_in_last),
        .busy           (busy),
        .blk_count      (blk_count)
    );

    typedef struct {
        logic [127:0] words;
        int           n;
        bit           last;
        logic [127:0] exp_data;
        bit           exp_last;
    } vec_t;

    vec_t vecs [6];

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_word(input logic [31:0] d, input bit l);
        int to = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (!s_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got s_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_block(input logic [127:0] w, input int n, input bit l);
        for (int i = 0; i < n; i++) begin
            push_word(w[127-32*i -: 32], l && (i == n - 1));
        end
    endtask

    task automatic idle_cycles(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (data_in_valid) pulses++;
        end
    endtask

    task automatic ack;
        data_out_valid = 1'b1;
        @(negedge clk);
        data_out_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        int acc_cnt;
        int idx;
        int sent;
        int cyc;
        bit acc;

        vecs[0] = '{words: 128'h00112233_44556677_8899AABB_CCDDEEFF, n: 4, last: 1'b0,
                    exp_data: 128'h00112233_44556677_8899AABB_CCDDEEFF, exp_last: 1'b0};
        vecs[1] = '{words: 128'hDEADBEEF_01234567_00000000_00000000, n: 2, last: 1'b1,
                    exp_data: 128'hDEADBEEF_01234567_00000000_00000000, exp_last: 1'b1};
        vecs[2] = '{words: 128'hA5A5A5A5_00000000_00000000_00000000, n: 1, last: 1'b1,
                    exp_data: 128'hA5A5A5A5_00000000_00000000_00000000, exp_last: 1'b1};
        vecs[3] = '{words: 128'h11111111_22222222_33333333_44444444, n: 4, last: 1'b1,
                    exp_data: 128'h11111111_22222222_33333333_44444444, exp_last: 1'b1};
        vecs[4] = '{words: 128'hCAFEF00D_0BADC0DE_12345678_FFFFFFFF, n: 3, last: 1'b1,
                    exp_data: 128'hCAFEF00D_0BADC0DE_12345678_00000000, exp_last: 1'b1};
        vecs[5] = '{words: 128'h00000009_00000008_00000007_00000006, n: 4, last: 1'b0,
                    exp_data: 128'h00000009_00000008_00000007_00000006, exp_last: 1'b0};

        rstn = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        rk_ready = 1'b1;
        aes_state = 1'b0;
        data_out_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_s_ready", s_ready, 1'b0);
        check1("rst_dv", data_in_valid, 1'b0);
        check128("rst_data_in", data_in, 128'd0);
        check1("rst_last", data_in_last, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check16("rst_blk_count", blk_count, 16'd0);
        rstn = 1'b0;
        @(negedge clk);
        check1("post_rst_s_ready", s_ready, 1'b1);
        $display("[TB] reset released");

        // Table-driven blocks, core acks each one
        for (int v = 0; v < 6; v++) begin
            push_block(vecs[v].words, vecs[v].n, vecs[v].last);
            check1("s_ready_drop", s_ready, 1'b0);
            check1("dv_t1", data_in_valid, 1'b0);
            check1("busy_t1", busy, 1'b1);
            @(negedge clk);
            check1("s_ready_rise", s_ready, 1'b1);
            check1("dv_t2", data_in_valid, 1'b0);
            @(negedge clk);
            check1("dv_t3", data_in_valid, 1'b1);
            check128("vec_data_in", data_in, vecs[v].exp_data);
            check1("vec_last", data_in_last, vecs[v].exp_last);
            check16("vec_blk_count", blk_count, 16'(v + 1));
            $display("[TB] vec %0d data_in=%h last=%b blk_count=%0d", v, data_in, data_in_last, blk_count);
            ack;
            check1("dv_one_cycle", data_in_valid, 1'b0);
            check1("busy_after_ack", busy, 1'b0);
        end

        // Core stalled: one block in flight, then A and H fill
        push_block(128'hF0F0F0F0_0F0F0F0F_F0F0F0F0_0F0F0F0F, 4, 1'b0);
        repeat (2) @(negedge clk);
        check1("stall_first_dv", data_in_valid, 1'b1);
        check16("stall_first_cnt", blk_count, 16'd7);
        acc_cnt = 0;
        idx = 0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            s_valid = (idx < 12);
            s_data  = 32'h100 + 32'(idx);
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) begin
                idx++;
                acc_cnt++;
            end
            @(negedge clk);
            if (data_in_valid) pulses++;
        end
        s_valid = 1'b0;
        checkint("stall_accepted", acc_cnt, 8);
        checkint("stall_pulses", pulses, 0);
        check1("stall_s_ready", s_ready, 1'b0);
        check1("stall_busy", busy, 1'b1);
        $display("[TB] stall: accepted %0d words, %0d pulses", acc_cnt, pulses);
        ack;
        check1("stall_no_same_cycle", data_in_valid, 1'b0);
        @(negedge clk);
        check1("stall_blk2_dv", data_in_valid, 1'b1);
        check128("stall_blk2_data", data_in, 128'h00000100_00000101_00000102_00000103);
        check16("stall_blk2_cnt", blk_count, 16'd8);
        ack;
        check1("stall_blk3_gap", data_in_valid, 1'b0);
        @(negedge clk);
        check1("stall_blk3_dv", data_in_valid, 1'b1);
        check128("stall_blk3_data", data_in, 128'h00000104_00000105_00000106_00000107);
        check16("stall_blk3_cnt", blk_count, 16'd9);
        $display("[TB] stall: blocks 2 and 3 issued, blk_count=%0d", blk_count);
        ack;
        @(negedge clk);
        check1("stall_drained_busy", busy, 1'b0);

        // Round keys not ready, then core busy
        rk_ready = 1'b0;
        push_block(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 4, 1'b0);
        idle_cycles(10, pulses);
        checkint("rk_low_pulses", pulses, 0);
        check1("rk_low_busy", busy, 1'b1);
        rk_ready = 1'b1;
        @(negedge clk);
        check1("rk_rise_dv", data_in_valid, 1'b1);
        check128("rk_rise_data", data_in, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        check16("rk_rise_cnt", blk_count, 16'd10);
        $display("[TB] rk_ready rise: data_in=%h", data_in);
        ack;
        aes_state = 1'b1;
        push_block(128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978, 4, 1'b0);
        idle_cycles(6, pulses);
        checkint("aes_busy_pulses", pulses, 0);
        aes_state = 1'b0;
        @(negedge clk);
        check1("aes_free_dv", data_in_valid, 1'b1);
        check16("aes_free_cnt", blk_count, 16'd11);
        $display("[TB] aes_state release: blk_count=%0d", blk_count);
        ack;

        // Reset while in WAIT with H full and A partially filled
        push_block(128'h01010101_02020202_03030303_04040404, 4, 1'b0);
        push_block(128'h05050505_06060606_07070707_08080808, 4, 1'b0);
        push_word(32'h09090909, 1'b0);
        check1("pre_rst_busy", busy, 1'b1);
        rstn = 1'b1;
        #1;
        check1("in_rst_s_ready", s_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        check1("mid_rst_dv", data_in_valid, 1'b0);
        check128("mid_rst_data", data_in, 128'd0);
        check1("mid_rst_last", data_in_last, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check16("mid_rst_cnt", blk_count, 16'd0);
        ack;
        idle_cycles(8, pulses);
        checkint("mid_rst_pulses", pulses, 0);
        check16("mid_rst_cnt_hold", blk_count, 16'd0);
        check1("mid_rst_busy_hold", busy, 1'b0);
        $display("[TB] mid-operation reset: blk_count=%0d busy=%b", blk_count, busy);

        // Counter wrap: one-word blocks, core acks immediately
        sent = 0;
        pulses = 0;
        cyc = 0;
        while (pulses < 65536 && cyc < 140000) begin
            data_out_valid = data_in_valid;
            if (data_in_valid) begin
                pulses++;
                if (pulses == 65535) check16("wrap_ffff", blk_count, 16'hFFFF);
                if (pulses == 65536) begin
                    check16("wrap_zero", blk_count, 16'd0);
                    check128("wrap_data", data_in, {32'd65535, 96'd0});
                    check1("wrap_last", data_in_last, 1'b1);
                end
            end
            s_valid = (sent < 65536);
            s_last  = 1'b1;
            s_data  = 32'(sent);
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
            cyc++;
        end
        data_out_valid = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        checkint("wrap_pulses", pulses, 65536);
        @(negedge clk);
        check16("wrap_final_cnt", blk_count, 16'd0);
        check1("wrap_final_busy", busy, 1'b0);
        $display("[TB] wrap: %0d blocks issued in %0d cycles, blk_count=%0d", pulses, cyc, blk_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
